id_exe_reg: RTL and testbench

- Pipeline register between the ID stage and the EXE stage of the ARM-subset 5-stage pipeline.
- Captures the ID control bundle, operand values, immediate fields, destination and source register numbers, PC, and the status-register carry each cycle.
- Supports freeze (memory stall), flush (taken branch) and bubble insertion, and tracks a valid bit per slot.
- Its outputs feed EXE and the hazard/forwarding unit.

---
 rtl/id_exe_reg.sv | 193 +++++++++++++++++++
 tb/tb_id_exe_reg.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: one instruction slot with freeze, flush and bubble handling.
// Optional event counters are compiled in when ID_EXE_STATS_EN is defined.
module id_exe_reg #(
  parameter int WORD_SIZE     = 32,
  parameter int REG_ADDR_SIZE = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     freeze,
  input  logic                     flush,
  input  logic                     valid_in,
  input  logic                     WB_EN_in,
  input  logic                     MEM_R_EN_in,
  input  logic                     MEM_W_EN_in,
  input  logic                     B_in,
  input  logic                     S_in,
  input  logic [3:0]               EXE_CMD_in,
  input  logic [WORD_SIZE-1:0]     PC_in,
  input  logic [WORD_SIZE-1:0]     Val_Rn_in,
  input  logic [WORD_SIZE-1:0]     Val_Rm_in,
  input  logic                     imm_in,
  input  logic [11:0]              Shift_operand_in,
  input  logic [23:0]              Signed_imm_24_in,
  input  logic [REG_ADDR_SIZE-1:0] Dest_in,
  input  logic [REG_ADDR_SIZE-1:0] src1_in,
  input  logic [REG_ADDR_SIZE-1:0] src2_in,
  input  logic                     C_in,
  output logic                     WB_EN_out,
  output logic                     MEM_R_EN_out,
  output logic                     MEM_W_EN_out,
  output logic                     B_out,
  output logic                     S_out,
  output logic [3:0]               EXE_CMD_out,
  output logic [WORD_SIZE-1:0]     PC_out,
  output logic [WORD_SIZE-1:0]     Val_Rn_out,
  output logic [WORD_SIZE-1:0]     Val_Rm_out,
  output logic                     imm_out,
  output logic [11:0]              Shift_operand_out,
  output logic [23:0]              Signed_imm_24_out,
  output logic [REG_ADDR_SIZE-1:0] Dest_out,
  output logic [REG_ADDR_SIZE-1:0] src1_out,
  output logic [REG_ADDR_SIZE-1:0] src2_out,
  output logic                     C_out,
  output logic                     valid_out
`ifdef ID_EXE_STATS_EN
  ,
  input  logic                     clear_stats,
  output logic [31:0]              bubble_count,
  output logic [31:0]              stall_count,
  output logic [15:0]              flush_count
`endif
);

  typedef struct packed {
    logic                     wb_en;
    logic                     mem_r_en;
    logic                     mem_w_en;
    logic                     b;
    logic                     s;
    logic [3:0]               exe_cmd;
    logic [WORD_SIZE-1:0]     pc;
    logic [WORD_SIZE-1:0]     val_rn;
    logic [WORD_SIZE-1:0]     val_rm;
    logic                     imm;
    logic [11:0]              shift_operand;
    logic [23:0]              signed_imm_24;
    logic [REG_ADDR_SIZE-1:0] dest;
    logic [REG_ADDR_SIZE-1:0] src1;
    logic [REG_ADDR_SIZE-1:0] src2;
    logic                     c;
  } slot_t;

  slot_t in_slot_s;
  slot_t slot_d, slot_q;
  logic  valid_d, valid_q;
  logic  bubble_s;

  assign in_slot_s = '{
    wb_en:         WB_EN_in,
    mem_r_en:      MEM_R_EN_in,
    mem_w_en:      MEM_W_EN_in,
    b:             B_in,
    s:             S_in,
    exe_cmd:       EXE_CMD_in,
    pc:            PC_in,
    val_rn:        Val_Rn_in,
    val_rm:        Val_Rm_in,
    imm:           imm_in,
    shift_operand: Shift_operand_in,
    signed_imm_24: Signed_imm_24_in,
    dest:          Dest_in,
    src1:          src1_in,
    src2:          src2_in,
    c:             C_in
  };

  // A killed or empty slot is fully zeroed so forwarding can never match a stale Dest.
  assign bubble_s = flush | ~valid_in;

  // Slot next-state: freeze holds, then bubble, then load.
  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (freeze) begin
      slot_d  = slot_q;
      valid_d = valid_q;
    end else if (bubble_s) begin
      slot_d  = '0;
      valid_d = 1'b0;
    end else begin
      slot_d  = in_slot_s;
      valid_d = 1'b1;
    end
  end

  // Slot register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  assign WB_EN_out         = slot_q.wb_en;
  assign MEM_R_EN_out      = slot_q.mem_r_en;
  assign MEM_W_EN_out      = slot_q.mem_w_en;
  assign B_out             = slot_q.b;
  assign S_out             = slot_q.s;
  assign EXE_CMD_out       = slot_q.exe_cmd;
  assign PC_out            = slot_q.pc;
  assign Val_Rn_out        = slot_q.val_rn;
  assign Val_Rm_out        = slot_q.val_rm;
  assign imm_out           = slot_q.imm;
  assign Shift_operand_out = slot_q.shift_operand;
  assign Signed_imm_24_out = slot_q.signed_imm_24;
  assign Dest_out          = slot_q.dest;
  assign src1_out          = slot_q.src1;
  assign src2_out          = slot_q.src2;
  assign C_out             = slot_q.c;
  assign valid_out         = valid_q;

`ifdef ID_EXE_STATS_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [15:0] flush_cnt_d, flush_cnt_q;

  // Counter next-state: clear wins, stalls counted only while frozen, events only when not.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (clear_stats) begin
      bubble_cnt_d = 32'd0;
      stall_cnt_d  = 32'd0;
      flush_cnt_d  = 16'd0;
    end else if (freeze) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      if (bubble_s) begin
        bubble_cnt_d = bubble_cnt_q + 32'd1;
      end else begin
        bubble_cnt_d = bubble_cnt_q;
      end
      if (flush) begin
        flush_cnt_d = flush_cnt_q + 16'd1;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bubble_cnt_q <= 32'd0;
      stall_cnt_q  <= 32'd0;
      flush_cnt_q  <= 16'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_count = bubble_cnt_q;
  assign stall_count  = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: directed scenarios plus randomized traffic
// against a table-driven reference of the freeze/flush/bubble/load rules.
module tb_id_exe_reg;
  localparam int W = 32;
  localparam int R = 4;

  typedef struct packed {
    logic         wb, mr, mw, b, s;
    logic [3:0]   cmd;
    logic [W-1:0] pc, rn, rm;
    logic         imm;
    logic [11:0]  sh;
    logic [23:0]  si;
    logic [R-1:0] dest, s1, s2;
    logic         c;
  } slot_t;

  logic  CLK = 1'b0;
  logic  RST, freeze, flush, valid_in;
  slot_t in_s, out_s, exp_s, zero_s;
  logic  exp_v;
  logic  WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, imm_out, C_out, valid_out;
  logic [3:0]   EXE_CMD_out;
  logic [W-1:0] PC_out, Val_Rn_out, Val_Rm_out;
  logic [11:0]  Shift_operand_out;
  logic [23:0]  Signed_imm_24_out;
  logic [R-1:0] Dest_out, src1_out, src2_out;
  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef ID_EXE_STATS_EN
  logic clear_stats;
  logic [31:0] bubble_count, stall_count, exp_bub, exp_stall;
  logic [15:0] flush_count, exp_fl;
`endif

  always #5 CLK = ~CLK;

  assign out_s = {WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, EXE_CMD_out, PC_out,
                  Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out, Signed_imm_24_out,
                  Dest_out, src1_out, src2_out, C_out};

  id_exe_reg #(.WORD_SIZE(W), .REG_ADDR_SIZE(R)) dut (
    .CLK(CLK), .RST(RST), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .WB_EN_in(in_s.wb), .MEM_R_EN_in(in_s.mr), .MEM_W_EN_in(in_s.mw), .B_in(in_s.b),
    .S_in(in_s.s), .EXE_CMD_in(in_s.cmd), .PC_in(in_s.pc), .Val_Rn_in(in_s.rn),
    .Val_Rm_in(in_s.rm), .imm_in(in_s.imm), .Shift_operand_in(in_s.sh),
    .Signed_imm_24_in(in_s.si), .Dest_in(in_s.dest), .src1_in(in_s.s1),
    .src2_in(in_s.s2), .C_in(in_s.c),
    .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
    .B_out(B_out), .S_out(S_out), .EXE_CMD_out(EXE_CMD_out), .PC_out(PC_out),
    .Val_Rn_out(Val_Rn_out), .Val_Rm_out(Val_Rm_out), .imm_out(imm_out),
    .Shift_operand_out(Shift_operand_out), .Signed_imm_24_out(Signed_imm_24_out),
    .Dest_out(Dest_out), .src1_out(src1_out), .src2_out(src2_out), .C_out(C_out),
    .valid_out(valid_out)
`ifdef ID_EXE_STATS_EN
    , .clear_stats(clear_stats), .bubble_count(bubble_count),
    .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  function automatic slot_t rand_slot();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return slot_t'(r[$bits(slot_t)-1:0]);
  endfunction

  // Reference: apply the priority table for one rising edge, then advance the clock.
  task automatic step();
    if (!freeze) begin
      if (flush || !valid_in) begin
        exp_s = zero_s;
        exp_v = 1'b0;
      end else begin
        exp_s = in_s;
        exp_v = 1'b1;
      end
    end
`ifdef ID_EXE_STATS_EN
    if (clear_stats) begin
      exp_bub = 32'd0; exp_stall = 32'd0; exp_fl = 16'd0;
    end else if (freeze) begin
      exp_stall = exp_stall + 32'd1;
    end else begin
      if (flush || !valid_in) exp_bub = exp_bub + 32'd1;
      if (flush) exp_fl = exp_fl + 16'd1;
    end
`endif
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    exp_s = zero_s;
    exp_v = 1'b0;
`ifdef ID_EXE_STATS_EN
    exp_bub = 32'd0; exp_stall = 32'd0; exp_fl = 16'd0;
`endif
  endtask

  task automatic test_reset();
    RST = 1'b1; freeze = 1'b1; flush = 1'b1; valid_in = 1'b1; in_s = '1;
`ifdef ID_EXE_STATS_EN
    clear_stats = 1'b0;
`endif
    model_reset();
    #12;
    total_cnt++;
    if (out_s !== zero_s || valid_out !== 1'b0) $display("FAIL reset_initial: got %h v=%b, want 0", out_s, valid_out);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0; freeze = 1'b0; flush = 1'b0; in_s = rand_slot();
    step();
    total_cnt++;
    if (out_s !== exp_s || valid_out !== 1'b1) $display("FAIL reset_first_load: got %h v=%b, want %h v=1", out_s, valid_out, exp_s);
    else pass_cnt++;
    in_s = '1; freeze = 1'b1; flush = 1'b1; valid_in = 1'b1;
    #2 RST = 1'b1;
    model_reset();
    #1;
    total_cnt++;
    if (out_s !== zero_s || valid_out !== 1'b0) $display("FAIL reset_async: got %h v=%b, want 0", out_s, valid_out);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0; freeze = 1'b0; flush = 1'b0;
    in_s = rand_slot(); in_s.cmd = 4'b0010; in_s.dest = 4'd5;
    step();
    total_cnt++;
    if (EXE_CMD_out !== 4'd2 || Dest_out !== 4'd5 || valid_out !== 1'b1 || out_s !== exp_s)
      $display("FAIL reset_release: got cmd=%0d dest=%0d v=%b, want cmd=2 dest=5 v=1", EXE_CMD_out, Dest_out, valid_out);
    else pass_cnt++;
  endtask

  task automatic test_freeze();
    in_s = rand_slot(); in_s.pc = 32'h10; valid_in = 1'b1;
    step();
    total_cnt++;
    if (PC_out !== 32'h10) $display("FAIL freeze_load: got %h, want 00000010", PC_out);
    else pass_cnt++;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_s = rand_slot(); in_s.pc = 32'h14 + 32'(4 * i);
      step();
      total_cnt++;
      if (PC_out !== 32'h10 || valid_out !== 1'b1) $display("FAIL freeze_hold: got pc=%h v=%b, want pc=00000010 v=1", PC_out, valid_out);
      else pass_cnt++;
    end
    freeze = 1'b0;
    step();
    total_cnt++;
    if (PC_out !== 32'h1C || out_s !== exp_s) $display("FAIL freeze_release: got pc=%h, want 0000001c", PC_out);
    else pass_cnt++;
  endtask

  task automatic test_flush_freeze();
    in_s = rand_slot(); in_s.wb = 1'b1; valid_in = 1'b1;
    step();
    flush = 1'b1; freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_s = rand_slot();
      step();
      total_cnt++;
      if (out_s !== exp_s || valid_out !== 1'b1) $display("FAIL flush_frozen_hold: got %h v=%b, want %h v=1", out_s, valid_out, exp_s);
      else pass_cnt++;
    end
    freeze = 1'b0;
    step();
    total_cnt++;
    if (valid_out !== 1'b0 || WB_EN_out !== 1'b0 || Dest_out !== 4'd0 || out_s !== zero_s)
      $display("FAIL flush_after_freeze: got %h v=%b, want 0 v=0", out_s, valid_out);
    else pass_cnt++;
    flush = 1'b0;
  endtask

  task automatic test_bubble();
    in_s = rand_slot(); in_s.wb = 1'b1; in_s.mw = 1'b1; in_s.dest = 4'd3; valid_in = 1'b0;
    step();
    total_cnt++;
    if (WB_EN_out !== 1'b0 || MEM_W_EN_out !== 1'b0 || Dest_out !== 4'd0 || valid_out !== 1'b0 || out_s !== zero_s)
      $display("FAIL upstream_bubble: got %h v=%b, want 0 v=0", out_s, valid_out);
    else pass_cnt++;
    valid_in = 1'b1;
  endtask

  task automatic test_streaming();
    slot_t q[$];
    slot_t want;
    for (int i = 0; i < 8; i++) begin
      in_s = rand_slot(); in_s.rn = 32'hA0 + 32'(i); in_s.c = i[0];
      q.push_back(in_s);
      step();
      want = q.pop_front();
      total_cnt++;
      if (out_s !== want || valid_out !== 1'b1) $display("FAIL stream_%0d: got %h v=%b, want %h v=1", i, out_s, valid_out, want);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back_flush();
    flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_s = rand_slot();
      step();
      total_cnt++;
      if (out_s !== zero_s || valid_out !== 1'b0) $display("FAIL b2b_flush_%0d: got %h v=%b, want 0 v=0", i, out_s, valid_out);
      else pass_cnt++;
    end
    flush = 1'b0; in_s = rand_slot();
    step();
    total_cnt++;
    if (out_s !== exp_s || valid_out !== 1'b1) $display("FAIL b2b_resume: got %h v=%b, want %h v=1", out_s, valid_out, exp_s);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    freeze = 1'b1; flush = 1'b1;
    step();
    #2 RST = 1'b1;
    model_reset();
    #1;
    total_cnt++;
    if (out_s !== zero_s || valid_out !== 1'b0) $display("FAIL reset_mid_stall: got %h v=%b, want 0", out_s, valid_out);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0; freeze = 1'b0; flush = 1'b0; valid_in = 1'b1; in_s = rand_slot();
    step();
    total_cnt++;
    if (out_s !== exp_s || valid_out !== 1'b1) $display("FAIL reset_resume: got %h v=%b, want %h v=1", out_s, valid_out, exp_s);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      freeze   = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 4) == 0);
      valid_in = ($urandom_range(0, 3) != 0);
      in_s     = rand_slot();
      step();
      total_cnt++;
      if (out_s !== exp_s || valid_out !== exp_v || (!valid_out && {WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out} !== 5'd0))
        $display("FAIL random_%0d: got %h v=%b, want %h v=%b", i, out_s, valid_out, exp_s, exp_v);
      else pass_cnt++;
    end
    freeze = 1'b0; flush = 1'b0; valid_in = 1'b1;
  endtask

`ifdef ID_EXE_STATS_EN
  task automatic test_stats();
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    flush = 1'b1;
    step(); step();
    flush = 1'b0; freeze = 1'b1;
    step(); step(); step();
    freeze = 1'b0; valid_in = 1'b0;
    step();
    valid_in = 1'b1;
    total_cnt++;
    if (bubble_count !== 32'd3 || stall_count !== 32'd3 || flush_count !== 16'd2 ||
        bubble_count !== exp_bub || stall_count !== exp_stall || flush_count !== exp_fl)
      $display("FAIL stats_counts: got b=%0d s=%0d f=%0d, want b=3 s=3 f=2", bubble_count, stall_count, flush_count);
    else pass_cnt++;
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    total_cnt++;
    if (bubble_count !== 32'd0 || stall_count !== 32'd0 || flush_count !== 16'd0)
      $display("FAIL stats_clear: got b=%0d s=%0d f=%0d, want 0 0 0", bubble_count, stall_count, flush_count);
    else pass_cnt++;
  endtask
`endif

  initial begin
    zero_s = '0;
    test_reset();
    test_freeze();
    test_flush_freeze();
    test_bubble();
    test_streaming();
    test_back_to_back_flush();
    test_reset_mid_stall();
    test_random();
`ifdef ID_EXE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
